// File: rtl/sm_accumulator_if.sv
// Bundle of the operand stream, result stream, block control and adder-side
// signals shared by the sign-magnitude accumulator and whatever surrounds it.
interface sm_accumulator_if #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
);
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_c;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               ovf;
    logic               busy;

    modport master (
        output start, len, in_valid, in_data, add_c, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_data, ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, add_c, out_ready,
        output in_ready, add_a, add_b, out_valid, out_data, ovf, busy
    );
endinterface

// File: rtl/sm_accumulator.sv
// Block accumulator for sign-magnitude words: feeds an external combinational
// adder, saturates on same-sign magnitude overflow and reports a sticky flag.
module sm_accumulator #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    sm_accumulator_if.slave    bus
);
    localparam int MAG_W = WIDTH - 1;
    localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {MAG_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [COUNT_W-1:0] cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;

    logic [WIDTH-1:0]   b_norm;
    logic [WIDTH-1:0]   c_norm;
    logic [WIDTH-1:0]   mag_sum;
    logic               sat;
    logic [WIDTH-1:0]   sum_next;
    logic               accept;

    // Any zero magnitude collapses to +0 so negative zero never propagates.
    function automatic logic [WIDTH-1:0] norm(input logic [WIDTH-1:0] w);
        return (w[MAG_W-1:0] == '0) ? '0 : w;
    endfunction

    assign b_norm   = norm(bus.in_data);
    assign c_norm   = norm(bus.add_c);
    assign mag_sum  = {1'b0, acc_reg[MAG_W-1:0]} + {1'b0, b_norm[MAG_W-1:0]};
    assign sat      = (acc_reg[WIDTH-1] == b_norm[WIDTH-1]) && (mag_sum > MAG_MAX);
    assign sum_next = sat ? {acc_reg[WIDTH-1], {MAG_W{1'b1}}} : c_norm;
    assign accept   = (state_reg == ACC) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    acc_next = '0;
                    ovf_next = 1'b0;
                    if (bus.len != '0) begin
                        cnt_next   = bus.len;
                        state_next = ACC;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_next = sum_next;
                    cnt_next = cnt_reg - COUNT_W'(1);
                    if (sat) begin
                        ovf_next = 1'b1;
                    end
                    if (cnt_reg == COUNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.add_a     = acc_reg;
    assign bus.add_b     = b_norm;
    assign bus.in_ready  = (state_reg == ACC);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_data  = (state_reg == DONE) ? acc_reg : '0;
    assign bus.ovf       = ovf_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator: models the external adder, predicts each
// block result with an integer model and checks it through a result queue.
module tb_sm_accumulator;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sm_accumulator_if #(.WIDTH(16), .COUNT_W(8)) bus();

    sm_accumulator #(.WIDTH(16), .COUNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Plain sign-magnitude adder; equal opposite magnitudes keep a's sign (may yield -0).
    function automatic logic [15:0] sm_add(input logic [15:0] a, input logic [15:0] b);
        logic [14:0] ma, mb;
        ma = a[14:0];
        mb = b[14:0];
        if (a[15] == b[15]) return {a[15], 15'(ma + mb)};
        if (ma >= mb) return {a[15], 15'(ma - mb)};
        return {b[15], 15'(mb - ma)};
    endfunction

    assign bus.add_c = sm_add(bus.add_a, bus.add_b);

    int n_checks = 0;
    int n_errors = 0;
    int mdl_acc;
    bit mdl_ovf;
    logic [16:0] exp_q[$];
    logic [15:0] beats[$];

    function automatic logic [15:0] enc(input int v);
        if (v < 0) return {1'b1, 15'(-v)};
        return {1'b0, 15'(v)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_block(input int l);
        bus.start = 1'b1;
        bus.len   = 8'(l);
        step();
        bus.start = 1'b0;
        mdl_acc   = 0;
        mdl_ovf   = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] w);
        int s;
        int m;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        #1;
        check("in_ready", bus.in_ready, 1);
        check("add_a", bus.add_a, enc(mdl_acc));
        check("add_b", bus.add_b, (w[14:0] == 15'd0) ? 16'h0000 : w);
        m = int'(w[14:0]);
        s = mdl_acc + (w[15] ? -m : m);
        if (s > 32767) begin
            s = 32767;
            mdl_ovf = 1'b1;
        end else if (s < -32767) begin
            s = -32767;
            mdl_ovf = 1'b1;
        end
        mdl_acc = s;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_beats(input int gap);
        for (int i = 0; i < beats.size(); i++) begin
            send_beat(beats[i]);
            if (i < beats.size() - 1) repeat (gap) step();
        end
        exp_q.push_back({mdl_ovf, enc(mdl_acc)});
    endtask

    task automatic collect(input string tag, input int hold);
        logic [16:0] e;
        logic [15:0] first_data;
        int w = 0;
        while (!bus.out_valid && w < 20) begin
            step();
            w++;
        end
        check($sformatf("%s out_valid", tag), bus.out_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
        first_data = bus.out_data;
        bus.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h0001;
            #1;
            check($sformatf("%s hold in_ready", tag), bus.in_ready, 0);
            check($sformatf("%s hold out_valid", tag), bus.out_valid, 1);
            check($sformatf("%s hold out_data", tag), bus.out_data, e[15:0]);
            step();
        end
        bus.in_valid = 1'b0;
        check($sformatf("%s out_data", tag), bus.out_data, e[15:0]);
        check($sformatf("%s ovf", tag), bus.ovf, e[16]);
        $display("%s: out_data=%h ovf=%b expected %h/%b", tag, first_data, bus.ovf, e[15:0], e[16]);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check($sformatf("%s out_valid after pop", tag), bus.out_valid, 0);
        check($sformatf("%s busy after pop", tag), bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst in_ready", bus.in_ready, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_data", bus.out_data, 0);
        check("rst busy", bus.busy, 0);
        check("rst ovf", bus.ovf, 0);
        reset = 1'b0;
        step();

        // Basic block, back-to-back beats, one-cycle result latency
        start_block(3);
        beats = '{16'h0005, 16'h8003, 16'h000a};
        run_beats(0);
        check("len3 latency out_valid", bus.out_valid, 1);
        collect("len3 sum", 0);

        // Positive saturation; ovf holds into IDLE
        start_block(2);
        beats = '{16'h7fff, 16'h0001};
        run_beats(0);
        collect("pos sat", 0);
        check("ovf held in idle", bus.ovf, 1);

        // Negative saturation
        start_block(2);
        beats = '{{1'b1, 15'd32000}, {1'b1, 15'd800}};
        run_beats(0);
        collect("neg sat", 0);

        // Cancellation to zero must come out as +0; start clears ovf
        start_block(2);
        check("ovf cleared by start", bus.ovf, 0);
        beats = '{16'h8007, 16'h0007};
        run_beats(0);
        collect("cancel zero", 0);

        // Negative zero operand
        start_block(1);
        beats = '{16'h8000};
        run_beats(0);
        collect("neg zero", 0);

        // Gapless reference then gapped run with held result
        start_block(4);
        beats = '{16'h0100, 16'h8040, 16'h0011, 16'h8300};
        run_beats(0);
        collect("len4 gapless", 0);
        start_block(4);
        run_beats(2);
        collect("len4 gapped", 5);

        // Zero-length block
        start_block(0);
        check("len0 out_valid next cycle", bus.out_valid, 1);
        exp_q.push_back({1'b0, 16'h0000});
        collect("len0", 0);

        // start during ACC must not reload the count
        start_block(3);
        send_beat(16'h0002);
        bus.start = 1'b1;
        bus.len   = 8'd1;
        step();
        bus.start = 1'b0;
        check("start in acc busy", bus.busy, 1);
        check("start in acc in_ready", bus.in_ready, 1);
        send_beat(16'h0003);
        send_beat(16'h0004);
        exp_q.push_back({mdl_ovf, enc(mdl_acc)});
        collect("start ignored", 0);

        // Reset mid-block discards it
        start_block(3);
        send_beat(16'h0064);
        reset = 1'b1;
        step();
        check("midrst in_ready", bus.in_ready, 0);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst out_data", bus.out_data, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst ovf", bus.ovf, 0);
        reset = 1'b0;
        step();
        check("midrst still idle", bus.out_valid, 0);
        start_block(1);
        beats = '{16'h0009};
        run_beats(0);
        collect("after reset", 0);

        check("queue drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
